// File: rtl/text_grid_writer_if.sv
// Character stream into the text grid: one character ID per valid/ready handshake.
interface text_grid_writer_if #(
  parameter int CHAR_ID_LENGTH = 8
);
  logic [CHAR_ID_LENGTH-1:0] in_char;
  logic                      in_valid;
  logic                      in_ready;

  modport master (output in_char, output in_valid, input in_ready);
  modport slave  (input in_char, input in_valid, output in_ready);
endinterface

// File: rtl/text_grid_writer.sv
// Character-ID grid behind the pixel encoder: writes an incoming character stream at a cursor
// and handles wrap, newline, backspace, scroll and clear through a single write port.
module text_grid_writer #(
  parameter int ROW_NUMBER     = 15,
  parameter int COL_NUMBER     = 40,
  parameter int ROW_BIT_LEN    = 4,
  parameter int COL_BIT_LEN    = 6,
  parameter int CHAR_ID_LENGTH = 8,
  parameter int TOTAL_CHAR     = 129,
  parameter int BLANK_ID       = 32,
  parameter int NEWLINE_ID     = 13,
  parameter int BACKSPACE_ID   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  text_grid_writer_if.slave         stream,
  input  logic                      clear,
  input  logic [ROW_BIT_LEN-1:0]    char_row,
  input  logic [COL_BIT_LEN-1:0]    char_col,
  output logic [CHAR_ID_LENGTH-1:0] character_id,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  localparam int CELLS  = ROW_NUMBER * COL_NUMBER;
  localparam int ADDR_W = $clog2(CELLS);

  typedef logic [ADDR_W-1:0]         addr_t;
  typedef logic [CHAR_ID_LENGTH-1:0] char_t;
  typedef logic [ROW_BIT_LEN-1:0]    row_t;
  typedef logic [COL_BIT_LEN-1:0]    col_t;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_SCROLL,
    S_BLANK
  } state_t;

  localparam addr_t CLEAR_LAST  = addr_t'(CELLS - 1);
  localparam addr_t SCROLL_LAST = addr_t'(CELLS - COL_NUMBER - 1);
  localparam addr_t ROW_STRIDE  = addr_t'(COL_NUMBER);
  localparam addr_t ADDR_ONE    = addr_t'(1);
  localparam row_t  LAST_ROW    = row_t'(ROW_NUMBER - 1);
  localparam col_t  LAST_COL    = col_t'(COL_NUMBER - 1);
  localparam row_t  ROW_ONE     = row_t'(1);
  localparam col_t  COL_ONE     = col_t'(1);
  localparam char_t BLANK       = char_t'(BLANK_ID);
  localparam char_t NEWLINE     = char_t'(NEWLINE_ID);
  localparam char_t BACKSPACE   = char_t'(BACKSPACE_ID);
  localparam char_t LAST_GLYPH  = char_t'(TOTAL_CHAR - 1);

  function automatic addr_t cell_addr(input row_t r, input col_t c);
    return addr_t'(r) * ROW_STRIDE + addr_t'(c);
  endfunction

  char_t  mem [CELLS];
  state_t state;
  addr_t  idx;

  logic   accept;
  logic   is_newline;
  logic   is_backspace;
  logic   is_glyph;
  logic   line_feed;
  logic   at_first_row;
  logic   at_last_row;
  logic   at_first_col;
  logic   at_last_col;

  logic   we;
  addr_t  waddr;
  char_t  wdata;

  assign stream.in_ready = (state == S_IDLE) && !clear;
  assign accept          = stream.in_valid && stream.in_ready;

  assign is_newline   = (stream.in_char == NEWLINE);
  assign is_backspace = (stream.in_char == BACKSPACE);
  assign is_glyph     = (stream.in_char <= LAST_GLYPH) && !is_newline && !is_backspace;

  assign at_first_row = (cursor_row == '0);
  assign at_last_row  = (cursor_row == LAST_ROW);
  assign at_first_col = (cursor_col == '0);
  assign at_last_col  = (cursor_col == LAST_COL);

  // Both a newline and a glyph landing in the last column move the cursor to the next line.
  assign line_feed = is_newline || (is_glyph && at_last_col);

  // Out-of-grid coordinates read as blank so the encoder can sweep past the text area.
  assign character_id = (char_row <= LAST_ROW && char_col <= LAST_COL)
                      ? mem[cell_addr(char_row, char_col)]
                      : BLANK;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    we    = 1'b0;
    waddr = idx;
    wdata = BLANK;
    unique case (state)
      S_CLEAR, S_BLANK: we = 1'b1;
      S_SCROLL: begin
        we    = 1'b1;
        wdata = mem[idx + ROW_STRIDE];
      end
      S_IDLE: begin
        if (accept) begin
          if (is_glyph) begin
            we    = 1'b1;
            waddr = cell_addr(cursor_row, cursor_col);
            wdata = stream.in_char;
          end else if (is_backspace && !at_first_col) begin
            we    = 1'b1;
            waddr = cell_addr(cursor_row, cursor_col - COL_ONE);
          end else if (is_backspace && !at_first_row) begin
            we    = 1'b1;
            waddr = cell_addr(cursor_row - ROW_ONE, LAST_COL);
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the grid array has no reset branch; the CLEAR sweep after reset initialises it cell by cell.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CLEAR;
      idx        <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      busy       <= 1'b1;
    end else begin
      unique case (state)
        S_CLEAR, S_BLANK: begin
          if (idx == CLEAR_LAST) begin
            state <= S_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + ADDR_ONE;
          end
        end

        S_SCROLL: begin
          idx <= idx + ADDR_ONE;
          if (idx == SCROLL_LAST) begin
            state <= S_BLANK;
          end
        end

        S_IDLE: begin
          if (clear) begin
            state      <= S_CLEAR;
            idx        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            busy       <= 1'b1;
          end else if (accept) begin
            if (line_feed) begin
              cursor_col <= '0;
              if (!at_last_row) begin
                cursor_row <= cursor_row + ROW_ONE;
              end else begin
                state <= S_SCROLL;
                idx   <= '0;
                busy  <= 1'b1;
              end
            end else if (is_glyph) begin
              cursor_col <= cursor_col + COL_ONE;
            end else if (is_backspace) begin
              if (!at_first_col) begin
                cursor_col <= cursor_col - COL_ONE;
              end else if (!at_first_row) begin
                cursor_row <= cursor_row - ROW_ONE;
                cursor_col <= LAST_COL;
              end
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_grid_writer.sv
// Directed bench for text_grid_writer: a reference grid model feeds a scoreboard of expected
// cell reads, compared against the combinational read port once the DUT has settled.
module tb_text_grid_writer;

  localparam int ROWS      = 15;
  localparam int COLS      = 40;
  localparam int BLANK     = 32;
  localparam int NEWLINE   = 13;
  localparam int BACKSPACE = 8;
  localparam int GLYPHS    = 129;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] char_row = '0;
  logic [5:0] char_col = '0;
  logic [7:0] character_id;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  text_grid_writer_if #(.CHAR_ID_LENGTH(8)) bus ();

  text_grid_writer dut (
    .clk          (clk),
    .reset        (reset),
    .stream       (bus),
    .clear        (clear),
    .char_row     (char_row),
    .char_col     (char_col),
    .character_id (character_id),
    .cursor_row   (cursor_row),
    .cursor_col   (cursor_col),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] row;
    logic [5:0] col;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t   sb [$];
  logic [7:0] model [ROWS][COLS];
  int         m_row;
  int         m_col;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] model_read(input int r, input int c);
    if (r >= ROWS || c >= COLS) return 8'(BLANK);
    return model[r][c];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 8'(BLANK);
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = model[r+1][c];
    for (int c = 0; c < COLS; c++) model[ROWS-1][c] = 8'(BLANK);
  endtask

  task automatic model_line_feed();
    m_col = 0;
    if (m_row < ROWS - 1) m_row++;
    else model_scroll();
  endtask

  task automatic model_apply(input logic [7:0] id);
    if (id == 8'(NEWLINE)) begin
      model_line_feed();
    end else if (id == 8'(BACKSPACE)) begin
      if (m_col > 0) begin
        m_col--;
        model[m_row][m_col] = 8'(BLANK);
      end else if (m_row > 0) begin
        m_row--;
        m_col = COLS - 1;
        model[m_row][m_col] = 8'(BLANK);
      end
    end else if (int'(id) < GLYPHS) begin
      model[m_row][m_col] = id;
      if (m_col < COLS - 1) m_col++;
      else model_line_feed();
    end
  endtask

  task automatic expect_cell(input string tag, input int r, input int c);
    sb_item_t it;
    it.tag = tag;
    it.row = 4'(r);
    it.col = 6'(c);
    it.exp = model_read(r, c);
    sb.push_back(it);
  endtask

  task automatic expect_grid(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) expect_cell(tag, r, c);
  endtask

  task automatic drain();
    sb_item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      char_row = it.row;
      char_col = it.col;
      #1;
      check($sformatf("%s(%0d,%0d)", it.tag, it.row, it.col), character_id, it.exp);
    end
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_cursor_row"}, cursor_row, m_row);
    check({tag, "_cursor_col"}, cursor_col, m_col);
  endtask

  task automatic send(input logic [7:0] id);
    int n = 0;
    @(negedge clk);
    bus.in_char  = id;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_apply(id);
  endtask

  // Call on the first busy negedge; drops in_valid the moment busy falls, before the next edge.
  task automatic wait_busy(input string tag, input int exp_cycles);
    int   n = 0;
    logic saw_ready = 1'b0;
    while (busy === 1'b1 && n < 5000) begin
      if (bus.in_ready !== 1'b0) saw_ready = 1'b1;
      n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check({tag, "_busy_cycles"}, n, exp_cycles);
    check({tag, "_ready_low"}, saw_ready, 0);
  endtask

  function automatic logic [7:0] fill_id(input int r, input int c);
    return 8'(33 + ((r * 7 + c) % 90));
  endfunction

  initial begin
    bus.in_char  = '0;
    bus.in_valid = 1'b0;
    model_clear();

    // T1: reset, 600-cycle clear, blank grid
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1);
    check("reset_ready", bus.in_ready, 0);
    reset = 1'b0;
    wait_busy("reset", 600);
    check_cursor("reset");
    expect_grid("reset_grid");
    drain();

    // T2: one glyph, then an out-of-range ID that must be dropped
    send(8'd65);
    expect_cell("t2_a", 0, 0);
    drain();
    check("t2_col_after_a", cursor_col, 1);
    check("t2_row_after_a", cursor_row, 0);
    send(8'd200);
    check("t2_col_after_drop", cursor_col, 1);
    expect_cell("t2_drop", 0, 1);
    drain();

    // T3: back to home, fill a row, wrap to (1,0), out-of-range reads
    send(8'(BACKSPACE));
    check_cursor("t3_home");
    for (int c = 0; c < COLS; c++) send(8'(33 + c));
    check("t3_row", cursor_row, 1);
    check("t3_col", cursor_col, 0);
    expect_cell("t3_last", 0, COLS - 1);
    expect_cell("t3_row_oob", ROWS, 0);
    expect_cell("t3_col_oob", 0, COLS);
    expect_cell("t3_both_oob", 15, 63);
    drain();
    check("t3_last_const", model_read(0, COLS - 1), 72);

    // T5: backspace across the row boundary, then down to home and one no-op
    send(8'(BACKSPACE));
    check("t5_row", cursor_row, 0);
    check("t5_col", cursor_col, COLS - 1);
    expect_cell("t5_blanked", 0, COLS - 1);
    drain();
    for (int c = 0; c < COLS - 1; c++) send(8'(BACKSPACE));
    check_cursor("t5_home");
    send(8'(BACKSPACE));
    check_cursor("t5_noop");
    for (int c = 0; c < COLS; c++) expect_cell("t5_row0", 0, c);
    drain();

    // T4: fill the grid, newline on the last row scrolls while in_valid is held
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == ROWS - 1 && c == COLS - 1)) send(fill_id(r, c));
    check("t4_pre_row", cursor_row, ROWS - 1);
    check("t4_pre_col", cursor_col, COLS - 1);
    send(8'(NEWLINE));
    bus.in_char  = 8'd99;
    bus.in_valid = 1'b1;
    @(negedge clk);
    wait_busy("t4_scroll", 600);
    check("t4_row", cursor_row, ROWS - 1);
    check("t4_col", cursor_col, 0);
    expect_grid("t4_grid");
    drain();

    // T4b: glyph written into the last cell also scrolls
    for (int c = 0; c < COLS; c++) send(8'(50 + c));
    @(negedge clk);
    wait_busy("t4b_scroll", 600);
    check_cursor("t4b");
    expect_grid("t4b_grid");
    drain();

    // T6: clear with a concurrent character is not accepted
    @(negedge clk);
    clear        = 1'b1;
    bus.in_char  = 8'd77;
    bus.in_valid = 1'b1;
    #1;
    check("t6_ready_under_clear", bus.in_ready, 0);
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    wait_busy("t6_clear", 600);
    check_cursor("t6_clear");
    expect_grid("t6_grid");
    drain();

    // T6: reset 100 cycles into a scroll restarts the full clear
    for (int c = 0; c < 5; c++) send(8'(70 + c));
    for (int r = 0; r < ROWS; r++) send(8'(NEWLINE));
    @(negedge clk);
    check("t6_scroll_busy", busy, 1);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_busy("t6_reset", 600);
    check_cursor("t6_reset");
    expect_grid("t6_reset_grid");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
